aes_encipher_iter: RTL

Iterative AES encipher datapath that owns the cipher state register and sequences the initial, main and final rounds for AES-128 and AES-256. Sits between the core control/API layer and the external key memory. The key memory supplies one 128-bit round key per requested round index. SubBytes width is parametrised, trading area against latency.

---
 rtl/aes_encipher_iter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_encipher_iter.sv
// Iterative AES-128/256 encipher datapath: initial, main and final rounds over an external key memory.
// SBOX_LANES selects 16 (one round per cycle) or 4 (one column per cycle); AES_ENC_ABORT_EN adds abort.
module aes_encipher_iter #(
    parameter int unsigned SBOX_LANES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic         ready,
    output logic         result_valid,
    output logic [127:0] result
`ifdef AES_ENC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam int unsigned SubCycles = (SBOX_LANES == 4) ? 4 : 1;

    // Byte x lives at bits [{~x, 3'b111} -: 8], so row 0 of the usual listing sits at the MSB end.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SboxTable[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = mix_column(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    typedef enum logic [1:0] {StIdle, StInit, StRound} st_e;

    st_e            st_q;
    logic [127:0]   state_q;
    logic           keylen_q;
    logic [1:0]     sub_q;
    logic [3:0]     round_q;
    logic           ready_q;
    logic           valid_q;
    logic [127:0]   result_q;

    logic [127:0]   sub_state;
    logic [127:0]   shifted;
    logic [127:0]   round_out;
    logic [3:0]     nr;
    logic           last_sub;
    logic           final_round;

    assign nr          = keylen_q ? 4'd14 : 4'd10;
    assign last_sub    = (sub_q == 2'(SubCycles - 1));
    assign final_round = (round_q == nr);

    if (SBOX_LANES == 16) begin : gen_full
        always_comb begin
            sub_state = '0;
            for (int i = 0; i < 16; i++) begin
                sub_state[127 - 8 * i -: 8] = sbox(state_q[127 - 8 * i -: 8]);
            end
        end
    end else if (SBOX_LANES == 4) begin : gen_column
        logic [31:0] col_in;
        logic [31:0] col_sub;
        logic [95:0] hold_q;

        always_comb begin
            col_in = '0;
            unique case (sub_q)
                2'd0:    col_in = state_q[127:96];
                2'd1:    col_in = state_q[95:64];
                2'd2:    col_in = state_q[63:32];
                default: col_in = state_q[31:0];
            endcase
            col_sub = '0;
            for (int j = 0; j < 4; j++) begin
                col_sub[31 - 8 * j -: 8] = sbox(col_in[31 - 8 * j -: 8]);
            end
        end

        // Columns 0..2 are parked here; column 3 joins combinationally in the last sub-cycle.
        always_ff @(posedge clk) begin
            if (reset) begin
                hold_q <= '0;
            end else if (st_q == StRound && !last_sub) begin
                case (sub_q)
                    2'd0:    hold_q[95:64] <= col_sub;
                    2'd1:    hold_q[63:32] <= col_sub;
                    default: hold_q[31:0]  <= col_sub;
                endcase
            end
        end

        assign sub_state = {hold_q, col_sub};
    end else begin : gen_bad_lanes
        $error("aes_encipher_iter: SBOX_LANES must be 4 or 16");
    end

    always_comb begin
        shifted   = shift_rows(sub_state);
        round_out = (final_round ? shifted : mix_columns(shifted)) ^ round_key;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q     <= StIdle;
            state_q  <= '0;
            keylen_q <= 1'b0;
            sub_q    <= 2'd0;
            round_q  <= 4'd0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
`ifdef AES_ENC_ABORT_EN
        end else if (abort && !ready_q) begin
            st_q    <= StIdle;
            sub_q   <= 2'd0;
            round_q <= 4'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= block;
                        keylen_q <= keylen;
                        ready_q  <= 1'b0;
                        st_q     <= StInit;
                    end
                end
                StInit: begin
                    state_q <= state_q ^ round_key;
                    round_q <= 4'd1;
                    sub_q   <= 2'd0;
                    st_q    <= StRound;
                end
                StRound: begin
                    if (last_sub) begin
                        sub_q <= 2'd0;
                        if (final_round) begin
                            result_q <= round_out;
                            valid_q  <= 1'b1;
                            ready_q  <= 1'b1;
                            round_q  <= 4'd0;
                            st_q     <= StIdle;
                        end else begin
                            state_q <= round_out;
                            round_q <= round_q + 4'd1;
                        end
                    end else begin
                        sub_q <= sub_q + 2'd1;
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign round        = round_q;
    assign ready        = ready_q;
    assign result_valid = valid_q;
    assign result       = result_q;

endmodule
